// File: rtl/pattern_matcher_pkg.sv
// Shared definitions for the pattern_matcher block.
//   state_e         : FSM encoding (IDLE / SCAN / DONE)
//   clog2           : ceiling log2, usable in constant expressions
//   calc_n_off      : number of bit offsets a window can take in the data word
//   calc_offset_w   : width of the offset counter / o_match_offset (minimum 1)
package pattern_matcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int calc_n_off(input int data_w, input int pattern_w);
    return data_w - pattern_w + 1;
  endfunction

  // A single offset still needs a 1-bit counter so ports never collapse to zero width.
  function automatic int calc_offset_w(input int data_w, input int pattern_w);
    int w;
    w = clog2(calc_n_off(data_w, pattern_w));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pattern_matcher_window_cmp.sv
// Combinational masked compare of one pattern-width window.
//   i_window  : data bits under the window
//   i_pattern : pattern to compare against
//   i_mask    : 1 = bit takes part in the compare
//   o_hit     : 1 when every masked bit of the window equals the pattern
module pattern_window_cmp #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_window,
  input  logic [W-1:0] i_pattern,
  input  logic [W-1:0] i_mask,
  output logic         o_hit
);

  assign o_hit = ((i_window ^ i_pattern) & i_mask) == '0;

endmodule

// File: rtl/pattern_matcher.sv
// Bit-serial sliding-window pattern matcher.
// Captures one data word, then compares the masked pattern against every bit
// offset of that word, lowest offset first, one offset per clock.
//   i_fclk / i_reset       : clock, synchronous active-high reset
//   i_data_valid, i_data   : data word from the source, sampled in IDLE only
//   i_pattern, i_mask      : pattern and compare mask, captured with the data
//   o_shift_result_valid   : one pulse per offset compared (every SCAN cycle)
//   o_result_valid         : scan finished, result held (DONE)
//   o_result_match         : a masked match was found
//   o_match_offset         : offset of the first match, 0 when none
//   i_result_reset         : clears the held result in DONE
//   o_busy                 : high in SCAN and DONE
//
// Handshake: the source asserts i_data_valid and keeps it high while it waits
// for the result; a word is taken only from IDLE. The result is held in DONE
// until the consumer pulses i_result_reset or drops i_data_valid, either of
// which (or both together) is a single clear back to IDLE.
module pattern_matcher
  import pattern_matcher_pkg::*;
#(
  parameter  int DATA_WIDTH    = 64,
  parameter  int PATTERN_WIDTH = 16,
  localparam int N_OFF         = calc_n_off(DATA_WIDTH, PATTERN_WIDTH),
  localparam int OFFSET_W      = calc_offset_w(DATA_WIDTH, PATTERN_WIDTH)
) (
  input  logic                     i_fclk,
  input  logic                     i_reset,
  input  logic                     i_data_valid,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic [PATTERN_WIDTH-1:0] i_pattern,
  input  logic [PATTERN_WIDTH-1:0] i_mask,
  output logic                     o_shift_result_valid,
  output logic                     o_result_valid,
  output logic                     o_result_match,
  output logic [OFFSET_W-1:0]      o_match_offset,
  input  logic                     i_result_reset,
  output logic                     o_busy
);

  if (PATTERN_WIDTH < 1 || PATTERN_WIDTH > DATA_WIDTH) begin : g_bad_width
    $error("pattern_matcher: PATTERN_WIDTH must be in 1..DATA_WIDTH");
  end

  localparam logic [OFFSET_W-1:0] LAST_K = OFFSET_W'(N_OFF - 1);

  state_e                   state_q,   state_d;
  logic [DATA_WIDTH-1:0]    data_q,    data_d;
  logic [PATTERN_WIDTH-1:0] pattern_q, pattern_d;
  logic [PATTERN_WIDTH-1:0] mask_q,    mask_d;
  logic [OFFSET_W-1:0]      k_q,       k_d;
  logic                     match_q,   match_d;
  logic [OFFSET_W-1:0]      offset_q,  offset_d;

  logic [PATTERN_WIDTH-1:0] window;
  logic                     hit;

  // Window at offset k is data[k+PATTERN_WIDTH-1:k]; shifting right then
  // truncating keeps the select in range for every parameterisation.
  assign window = PATTERN_WIDTH'(data_q >> k_q);

  pattern_window_cmp #(
    .W (PATTERN_WIDTH)
  ) u_cmp (
    .i_window  (window),
    .i_pattern (pattern_q),
    .i_mask    (mask_q),
    .o_hit     (hit)
  );

  always_ff @(posedge i_fclk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      pattern_q <= '0;
      mask_q    <= '0;
      k_q       <= '0;
      match_q   <= 1'b0;
      offset_q  <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      k_q       <= k_d;
      match_q   <= match_d;
      offset_q  <= offset_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    k_d       = k_q;
    match_d   = match_q;
    offset_d  = offset_q;
    case (state_q)
      IDLE: begin
        if (i_data_valid) begin
          data_d    = i_data;
          pattern_d = i_pattern;
          mask_d    = i_mask;
          k_d       = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          match_d  = 1'b1;
          offset_d = k_q;
          state_d  = DONE;
        end else if (k_q == LAST_K) begin
          match_d  = 1'b0;
          offset_d = '0;
          state_d  = DONE;
        end else begin
          k_d = k_q + OFFSET_W'(1);
        end
      end
      DONE: begin
        // Clear the result on the way out so it reads 0 in the next cycle.
        if (i_result_reset || !i_data_valid) begin
          match_d  = 1'b0;
          offset_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_shift_result_valid = (state_q == SCAN);
  assign o_result_valid       = (state_q == DONE);
  assign o_result_match       = match_q;
  assign o_match_offset       = offset_q;
  assign o_busy               = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_matcher.sv
// Directed bench for pattern_matcher: default 64/16 build (a_*) and a 64/64
// build (b_*) sharing one clock and reset.
module tb_pattern_matcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        a_dv, a_rr;
  logic [63:0] a_data;
  logic [15:0] a_pat, a_mask;
  logic        a_shift, a_valid, a_match, a_busy;
  logic [5:0]  a_off;

  logic        b_dv, b_rr;
  logic [63:0] b_data;
  logic [63:0] b_pat, b_mask;
  logic        b_shift, b_valid, b_match, b_busy;
  logic [0:0]  b_off;

  int n_cmp = 0;
  int n_mis = 0;

  pattern_matcher #(.DATA_WIDTH(64), .PATTERN_WIDTH(16)) u_dut_a (
    .i_fclk(clk), .i_reset(rst), .i_data_valid(a_dv), .i_data(a_data),
    .i_pattern(a_pat), .i_mask(a_mask), .o_shift_result_valid(a_shift),
    .o_result_valid(a_valid), .o_result_match(a_match),
    .o_match_offset(a_off), .i_result_reset(a_rr), .o_busy(a_busy)
  );

  pattern_matcher #(.DATA_WIDTH(64), .PATTERN_WIDTH(64)) u_dut_b (
    .i_fclk(clk), .i_reset(rst), .i_data_valid(b_dv), .i_data(b_data),
    .i_pattern(b_pat), .i_mask(b_mask), .o_shift_result_valid(b_shift),
    .o_result_valid(b_valid), .o_result_match(b_match),
    .o_match_offset(b_off), .i_result_reset(b_rr), .o_busy(b_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, counting a shift pulse seen in the current cycle.
  task automatic step(input bit sel, inout int pulses, inout int cyc);
    if (sel ? b_shift : a_shift) pulses++;
    @(posedge clk); #1;
    cyc++;
  endtask

  // Present a word with i_data_valid; returns observing cycle 1.
  task automatic start_scan(input bit sel, input logic [63:0] data,
                            input logic [63:0] pat, input logic [63:0] mask);
    if (sel) begin
      b_data = data; b_pat = pat; b_mask = mask; b_dv = 1'b1;
    end else begin
      a_data = data; a_pat = pat[15:0]; a_mask = mask[15:0]; a_dv = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input bit sel, inout int pulses, inout int cyc);
    int guard;
    guard = 0;
    while (!(sel ? b_valid : a_valid) && guard < 200) begin
      step(sel, pulses, cyc);
      guard++;
    end
    if (!(sel ? b_valid : a_valid)) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_result(input bit sel);
    if (sel) begin b_rr = 1'b1; b_dv = 1'b0; end
    else     begin a_rr = 1'b1; a_dv = 1'b0; end
    @(posedge clk); #1;
    a_rr = 1'b0; b_rr = 1'b0;
  endtask

  initial begin
    int pulses, cyc;
    rst = 1'b1;
    a_dv = 0; a_rr = 0; a_data = '0; a_pat = '0; a_mask = '0;
    b_dv = 0; b_rr = 0; b_data = '0; b_pat = '0; b_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_busy",  a_busy,  0);
    check_eq("rst_a_valid", a_valid, 0);
    check_eq("rst_a_match", a_match, 0);
    check_eq("rst_a_off",   a_off,   0);
    check_eq("rst_a_shift", a_shift, 0);
    check_eq("rst_b_busy",  b_busy,  0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Match at offset 8
    start_scan(0, 64'h0000_0000_00AB_CD00, 16'hABCD, 16'hFFFF);
    pulses = 0; cyc = 1;
    wait_done(0, pulses, cyc);
    check_eq("m8_pulses", pulses, 9);
    check_eq("m8_cycle",  cyc,    10);
    check_eq("m8_match",  a_match, 1);
    check_eq("m8_off",    a_off,   8);
    check_eq("m8_busy",   a_busy,  1);
    step(0, pulses, cyc);
    check_eq("m8_hold_valid", a_valid, 1);
    check_eq("m8_hold_off",   a_off,   8);
    check_eq("m8_no_pulse_in_done", pulses, 9);
    clear_result(0);
    check_eq("clr_valid", a_valid, 0);
    check_eq("clr_match", a_match, 0);
    check_eq("clr_off",   a_off,   0);
    check_eq("clr_busy",  a_busy,  0);

    // No match anywhere
    start_scan(0, 64'h0, 16'h0001, 16'hFFFF);
    pulses = 0; cyc = 1;
    wait_done(0, pulses, cyc);
    check_eq("nm_pulses", pulses, 49);
    check_eq("nm_cycle",  cyc,    50);
    check_eq("nm_match",  a_match, 0);
    check_eq("nm_off",    a_off,   0);
    // Leave DONE by dropping i_data_valid alone
    a_dv = 1'b0;
    @(posedge clk); #1;
    check_eq("dvdrop_busy",  a_busy,  0);
    check_eq("dvdrop_valid", a_valid, 0);

    // All-zero mask hits immediately
    start_scan(0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 16'h0000);
    pulses = 0; cyc = 1;
    wait_done(0, pulses, cyc);
    check_eq("mz_pulses", pulses, 1);
    check_eq("mz_cycle",  cyc,    2);
    check_eq("mz_match",  a_match, 1);
    check_eq("mz_off",    a_off,   0);
    clear_result(0);

    // Single masked bit never matches
    start_scan(0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 16'h0001);
    pulses = 0; cyc = 1;
    wait_done(0, pulses, cyc);
    check_eq("m1_pulses", pulses, 49);
    check_eq("m1_match",  a_match, 0);
    clear_result(0);

    // Inputs changing during SCAN are ignored, as is i_result_reset
    start_scan(0, 64'h0000_0000_00AB_CD00, 16'hABCD, 16'hFFFF);
    pulses = 0; cyc = 1;
    a_dv = 1'b0; a_rr = 1'b1; a_pat = 16'h1234; a_mask = 16'h0000; a_data = 64'h0;
    step(0, pulses, cyc);
    a_dv = 1'b1; a_rr = 1'b0;
    step(0, pulses, cyc);
    wait_done(0, pulses, cyc);
    check_eq("hold_pulses", pulses, 9);
    check_eq("hold_cycle",  cyc,    10);
    check_eq("hold_match",  a_match, 1);
    check_eq("hold_off",    a_off,   8);
    clear_result(0);

    // Reset in the middle of a scan
    start_scan(0, 64'h0, 16'h0001, 16'hFFFF);
    pulses = 0; cyc = 1;
    while (cyc < 5) step(0, pulses, cyc);
    check_eq("rs_pulses_before", pulses, 4);
    rst = 1'b1; a_dv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rs_busy",  a_busy,  0);
    check_eq("rs_shift", a_shift, 0);
    check_eq("rs_valid", a_valid, 0);
    check_eq("rs_off",   a_off,   0);
    pulses = 0;
    repeat (5) step(0, pulses, cyc);
    check_eq("rs_pulses_after", pulses, 0);

    // Full-width pattern build
    start_scan(1, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF);
    pulses = 0; cyc = 1;
    wait_done(1, pulses, cyc);
    check_eq("fw_eq_pulses", pulses, 1);
    check_eq("fw_eq_cycle",  cyc,    2);
    check_eq("fw_eq_match",  b_match, 1);
    check_eq("fw_eq_off",    b_off,   0);
    clear_result(1);
    start_scan(1, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567 ^ (64'd1 << 37),
               64'hFFFF_FFFF_FFFF_FFFF);
    pulses = 0; cyc = 1;
    wait_done(1, pulses, cyc);
    check_eq("fw_ne_pulses", pulses, 1);
    check_eq("fw_ne_cycle",  cyc,    2);
    check_eq("fw_ne_match",  b_match, 0);
    clear_result(1);
    check_eq("fw_clr_busy", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
